// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and defaults
package uart_pkg;

    localparam int DATA_WIDTH = 32;

    typedef struct packed {
        logic                  err;
        logic [DATA_WIDTH-1:0] data;
    } rx_entry_t;

endpackage

// File: rtl/uart_fifo_ram.sv
// rtl/uart_fifo_ram.sv - DEPTH x WIDTH storage, synchronous write, asynchronous read
module uart_fifo_ram #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - receive frame FIFO with status, threshold interrupt and sticky overrun
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = uart_pkg::DATA_WIDTH,
    parameter int DEPTH      = 16,
    parameter int AW         = $clog2(DEPTH)
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  rx_done,
    input  logic                  rx_error,
    input  logic [DATA_WIDTH-1:0] rx_data_in,
    input  logic                  rd_en,
    input  logic                  fifo_clr,
    input  logic [AW:0]           thr,
    input  logic                  overrun_clr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_err,
    output logic                  empty,
    output logic                  full,
    output logic [AW:0]           count,
    output logic                  rx_irq,
    output logic                  overrun
);

    typedef struct packed {
        logic                  err;
        logic [DATA_WIDTH-1:0] data;
    } entry_t;

    localparam logic [AW:0] L_FULL = (AW+1)'(DEPTH);

    logic          r_done_q;
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          r_overrun;

    logic   w_push;
    logic   w_empty;
    logic   w_full;
    logic   w_pop;
    logic   w_push_ok;
    logic   w_drop;
    entry_t w_wr_entry;
    entry_t w_rd_entry;

    assign w_push    = rx_done & ~r_done_q;
    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == L_FULL);
    assign w_pop     = rd_en & ~w_empty & ~fifo_clr;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_push_ok = w_push & ~fifo_clr & (~w_full | w_pop);
    assign w_drop    = w_push & ~fifo_clr & w_full & ~w_pop;

    assign w_wr_entry.err  = rx_error;
    assign w_wr_entry.data = rx_data_in;

    uart_fifo_ram #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .i_clk   (PCLK),
        .i_we    (w_push_ok),
        .i_waddr (r_wr_ptr),
        .i_wdata (w_wr_entry),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rd_entry)
    );

    // done_q resets high so a level already present at reset release is not a new frame.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_done_q <= 1'b1;
        end else begin
            r_done_q <= rx_done;
        end
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (fifo_clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push_ok && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push_ok) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_overrun <= 1'b0;
        end else if (w_drop) begin
            r_overrun <= 1'b1;
        end else if (overrun_clr) begin
            r_overrun <= 1'b0;
        end
    end

    assign rd_data = w_rd_entry.data;
    assign rd_err  = w_rd_entry.err;
    assign empty   = w_empty;
    assign full    = w_full;
    assign count   = r_count;
    assign rx_irq  = (thr != '0) && (r_count >= thr);
    assign overrun = r_overrun;

endmodule
